// File: rtl/irq_pkg.sv
// Shared constants for the platform interrupt controller:
// register offsets, default priority width and source-ID width.
package irq_pkg;

    localparam int PRIO_W_DEF  = 3;
    localparam int ID_W        = 5;

    localparam int PRIO_BASE   = 'h000;
    localparam int PENDING_OFF = 'h080;
    localparam int ENABLE_OFF  = 'h100;
    localparam int THRESH_OFF  = 'h200;
    localparam int CLAIM_OFF   = 'h204;

endpackage

// File: rtl/irq_arbiter.sv
// Combinational max-priority picker over enabled pending sources.
// Strict compare while scanning upward keeps ties on the lowest ID.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = PRIO_W_DEF
) (
    input  logic [NUM_SRC:0]             cand,
    input  logic [NUM_SRC:0][PRIO_W-1:0] prio,
    output logic [ID_W-1:0]              best_id,
    output logic [PRIO_W-1:0]            best_prio
);

    logic unused_ok;
    assign unused_ok = ^{cand[0], prio[0]};

    // Priority 0 never beats the initial best_prio of 0, so it is
    // excluded from candidacy without a separate test.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (cand[i] && (prio[i] > best_prio)) begin
                best_id   = ID_W'(i);
                best_prio = prio[i];
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Platform interrupt controller: level gateways, claim/complete,
// priority/threshold arbitration and an APB register port.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_SRC    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h11010000,
    parameter int                    PRIO_W     = PRIO_W_DEF
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    input  logic [NUM_SRC-1:0]    irq_src,
    output logic                  ext_irq
);

    localparam logic [ID_W-1:0] MAX_ID = ID_W'(NUM_SRC);

    logic [NUM_SRC:0][PRIO_W-1:0] prio_q, prio_d;
    logic [NUM_SRC:0]             pending_q, pending_d;
    logic [NUM_SRC:0]             enable_q, enable_d;
    logic [NUM_SRC:0]             inflight_q, inflight_d;
    logic [PRIO_W-1:0]            thresh_q, thresh_d;
    logic                         pready_q, pready_d;
    logic                         perr_q, perr_d;
    logic                         ext_irq_q, ext_irq_d;
    logic [DATA_WIDTH-1:0]        prdata_q, prdata_d;

    logic [ADDR_WIDTH-1:0] off;
    logic [ID_W-1:0]       idx;
    logic [ID_W-1:0]       cmp_id;
    logic [ID_W-1:0]       best_id;
    logic [PRIO_W-1:0]     best_prio;
    logic [PRIO_W-1:0]     prio_rd;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] en_wr;
    logic                  access;
    logic                  sel_prio, sel_pend, sel_en;
    logic                  sel_thr, sel_claim;
    logic                  err;
    logic                  do_wr, do_rd;
    logic                  do_prio, do_claim, do_cmpl;
    logic                  unused_ok;

    assign off    = paddr - BASE_ADDR;
    assign idx    = off[2 +: ID_W];
    assign cmp_id = pdata[ID_W-1:0];
    assign access = psel && penable && !pready_q;

    assign sel_prio  = (off < ADDR_WIDTH'(PENDING_OFF))
                    && (off[1:0] == 2'b00)
                    && (idx <= MAX_ID);
    assign sel_pend  = (off == ADDR_WIDTH'(PENDING_OFF));
    assign sel_en    = (off == ADDR_WIDTH'(ENABLE_OFF));
    assign sel_thr   = (off == ADDR_WIDTH'(THRESH_OFF));
    assign sel_claim = (off == ADDR_WIDTH'(CLAIM_OFF));

    assign err = !(sel_prio || sel_pend || sel_en
                || sel_thr || sel_claim)
              || (sel_pend && pwrite);

    assign do_wr    = access && !err && pwrite;
    assign do_rd    = access && !err && !pwrite;
    assign do_prio  = do_wr && sel_prio && pstb[0];
    assign do_cmpl  = do_wr && sel_claim && pstb[0];
    assign do_claim = do_rd && sel_claim;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            wmask[b*8 +: 8] = {8{pstb[b]}};
        end
    end

    assign en_wr = (DATA_WIDTH'(enable_q) & ~wmask)
                 | (pdata & wmask);

    assign unused_ok = ^{en_wr, off};

    irq_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .cand      (pending_q & enable_q),
        .prio      (prio_q),
        .best_id   (best_id),
        .best_prio (best_prio)
    );

    always_comb begin
        prio_rd = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (idx == ID_W'(i)) prio_rd = prio_q[i];
        end
    end

    always_comb begin
        unique case (1'b1)
            sel_prio:  rdata = DATA_WIDTH'(prio_rd);
            sel_pend:  rdata = DATA_WIDTH'(pending_q);
            sel_en:    rdata = DATA_WIDTH'(enable_q);
            sel_thr:   rdata = DATA_WIDTH'(thresh_q);
            sel_claim: rdata = DATA_WIDTH'(best_id);
            default:   rdata = '0;
        endcase
    end

    // Gateways: a line pends only while neither pending nor in
    // service; claim and complete act on the same pass.
    always_comb begin
        prio_d     = prio_q;
        pending_d  = pending_q;
        inflight_d = inflight_q;
        enable_d   = enable_q;
        thresh_d   = thresh_q;
        pready_d   = access;
        perr_d     = access && err;
        prdata_d   = '0;
        ext_irq_d  = (best_id != '0) && (best_prio > thresh_q);

        for (int i = 1; i <= NUM_SRC; i++) begin
            if (irq_src[i-1] && !pending_q[i] && !inflight_q[i])
                pending_d[i] = 1'b1;
            if (do_claim && (best_id == ID_W'(i))) begin
                pending_d[i]  = 1'b0;
                inflight_d[i] = 1'b1;
            end
            if (do_cmpl && (cmp_id == ID_W'(i)))
                inflight_d[i] = 1'b0;
            if (do_prio && (idx == ID_W'(i)))
                prio_d[i] = pdata[PRIO_W-1:0];
        end

        if (do_wr && sel_en)
            enable_d = en_wr[NUM_SRC:0] & ~(NUM_SRC+1)'(1);
        if (do_wr && sel_thr && pstb[0])
            thresh_d = pdata[PRIO_W-1:0];
        if (do_rd)
            prdata_d = rdata;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            prio_q     <= '0;
            pending_q  <= '0;
            inflight_q <= '0;
            enable_q   <= '0;
            thresh_q   <= '0;
            pready_q   <= 1'b0;
            perr_q     <= 1'b0;
            prdata_q   <= '0;
            ext_irq_q  <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            enable_q   <= enable_d;
            thresh_q   <= thresh_d;
            pready_q   <= pready_d;
            perr_q     <= perr_d;
            prdata_q   <= prdata_d;
            ext_irq_q  <= ext_irq_d;
        end
    end

    assign pready  = pready_q;
    assign perr    = perr_q;
    assign prdata  = prdata_q;
    assign ext_irq = ext_irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register access, gateway timing,
// arbitration, claim/complete and reset behaviour.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h1101_0000;
    localparam logic [31:0] PEND = BASE + 32'h080;
    localparam logic [31:0] EN   = BASE + 32'h100;
    localparam logic [31:0] THR  = BASE + 32'h200;
    localparam logic [31:0] CLM  = BASE + 32'h204;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pdata = '0;
    logic [31:0] prdata;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  pstb = 4'hF;
    logic        pready;
    logic        perr;
    logic [7:0]  irq_src = '0;
    logic        ext_irq;

    int total = 0;
    int bad   = 0;

    irq_ctrl dut (
        .pclk    (pclk),
        .presetn (presetn),
        .paddr   (paddr),
        .pdata   (pdata),
        .prdata  (prdata),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pstb    (pstb),
        .pready  (pready),
        .perr    (perr),
        .irq_src (irq_src),
        .ext_irq (ext_irq)
    );

    always #5 pclk = ~pclk;

    function automatic logic [31:0] prio_a(input int i);
        return BASE + 32'(4 * i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic wr,
                        input logic [31:0] wd,
                        output logic [31:0] d, output logic e);
        int n;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(posedge pclk); #1;
            n++;
        end while (!pready && n < 8);
        chk("pready_rise", 32'(pready), 32'd1);
        d = prdata;
        e = perr;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1;
        chk("pready_pulse", 32'(pready), 32'd0);
    endtask

    task automatic wr_ok(input string tag, input logic [31:0] a,
                         input logic [31:0] wd);
        logic [31:0] d;
        logic e;
        xfer(a, 1'b1, wd, d, e);
        chk(tag, 32'(e), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        xfer(a, 1'b0, '0, d, e);
        chk(tag, d, exp);
        chk({tag, "_perr"}, 32'(e), 32'd0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic e;

        cyc(2);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_ext", 32'(ext_irq), 32'd0);
        presetn = 1'b1;
        cyc(1);

        rd_chk("claim0", CLM, 32'd0);
        rd_chk("pend0", PEND, 32'd0);
        rd_chk("thr0", THR, 32'd0);
        chk("ext0", 32'(ext_irq), 32'd0);

        wr_ok("w_prio3", prio_a(3), 32'd2);
        wr_ok("w_en", EN, 32'h08);
        wr_ok("w_thr", THR, 32'd1);
        @(posedge pclk); #1;
        irq_src[2] = 1'b1;
        cyc(1);
        chk("ext_n1", 32'(ext_irq), 32'd0);
        cyc(1);
        chk("ext_n2", 32'(ext_irq), 32'd1);
        rd_chk("pend3", PEND, 32'h08);

        rd_chk("claim3", CLM, 32'd3);
        chk("ext_fall", 32'(ext_irq), 32'd0);
        rd_chk("no_repend", PEND, 32'h00);

        wr_ok("cmpl3", CLM, 32'd3);
        rd_chk("repend", PEND, 32'h08);
        chk("ext_repend", 32'(ext_irq), 32'd1);
        irq_src[2] = 1'b0;
        rd_chk("claim3b", CLM, 32'd3);
        wr_ok("cmpl3b", CLM, 32'd3);
        cyc(2);
        chk("ext_quiet", 32'(ext_irq), 32'd0);
        rd_chk("pend_quiet", PEND, 32'h00);

        wr_ok("w_prio2", prio_a(2), 32'd4);
        wr_ok("w_prio5", prio_a(5), 32'd4);
        wr_ok("w_en25", EN, 32'h24);
        irq_src = 8'b0001_0010;
        cyc(2);
        rd_chk("tie_2", CLM, 32'd2);
        rd_chk("tie_5", CLM, 32'd5);
        wr_ok("cmpl2", CLM, 32'd2);
        wr_ok("cmpl5", CLM, 32'd5);
        cyc(2);
        wr_ok("w_prio5_6", prio_a(5), 32'd6);
        rd_chk("hi_5", CLM, 32'd5);
        wr_ok("cmpl5b", CLM, 32'd5);
        cyc(2);
        wr_ok("w_thr6", THR, 32'd6);
        cyc(2);
        chk("ext_thr", 32'(ext_irq), 32'd0);
        rd_chk("thr_claim5", CLM, 32'd5);
        rd_chk("thr_claim2", CLM, 32'd2);
        irq_src = '0;
        wr_ok("cmpl2b", CLM, 32'd2);
        wr_ok("cmpl5c", CLM, 32'd5);

        xfer(BASE + 32'h300, 1'b0, '0, d, e);
        chk("oob_perr", 32'(e), 32'd1);
        chk("oob_data", d, 32'd0);
        wr_ok("w_prio0", prio_a(0), 32'd7);
        rd_chk("prio0", prio_a(0), 32'd0);
        wr_ok("w_prio1", prio_a(1), 32'd7);
        wr_ok("w_en1", EN, 32'h03);
        rd_chk("en_bit0", EN, 32'h02);
        irq_src = 8'h01;
        cyc(2);
        chk("ext_id1", 32'(ext_irq), 32'd1);
        xfer(PEND, 1'b1, 32'h0, d, e);
        chk("wpend_perr", 32'(e), 32'd1);
        rd_chk("pend_kept", PEND, 32'h02);
        rd_chk("claim1", CLM, 32'd1);
        wr_ok("cmpl_id0", CLM, 32'd0);
        wr_ok("cmpl_id9", CLM, 32'd9);
        rd_chk("pend_inflt", PEND, 32'h00);
        wr_ok("cmpl1", CLM, 32'd1);
        rd_chk("pend_id1", PEND, 32'h02);

        irq_src = '0;
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; paddr = THR; pdata = 32'd3;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        chk("mid_pready", 32'(pready), 32'd1);
        presetn = 1'b0;
        #1;
        chk("abort_pready", 32'(pready), 32'd0);
        chk("abort_ext", 32'(ext_irq), 32'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        cyc(2);
        presetn = 1'b1;
        cyc(1);
        rd_chk("rst_thr", THR, 32'd0);
        rd_chk("rst_pend", PEND, 32'd0);
        rd_chk("rst_en", EN, 32'd0);
        rd_chk("rst_prio1", prio_a(1), 32'd0);
        rd_chk("rst_claim", CLM, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
